// File: rtl/usb_sie_tx.sv
// USB SIE packet transmitter: emits handshake packets (PID) or data packets
// (PID, payload, CRC16) byte by byte to the transceiver TX byte interface.
module usb_sie_tx #(
  parameter int MAX_LEN = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] pid,
  input  logic       has_data,
  input  logic       zlp,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  input  logic       pl_last,
  output logic       pl_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int CW = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI} state_t;

  state_t         state_q, state_d;
  logic           load_pid, take_hold, send_lo, send_hi, finish, underrun, accept;
  logic [15:0]    crc_q;
  logic [7:0]     hold_data;
  logic           hold_full, hold_last, fetch_done, hd_q, zlp_q, cur_last, ovf_q;
  logic [CW-1:0]  fetch_cnt;

  // Reflected CRC16 (poly 0xA001), one payload byte at a time.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  // Fetching stops once the final byte (real or length-forced) sits in the hold.
  assign pl_ready = busy & hd_q & ~zlp_q & ~hold_full & ~fetch_done;
  assign accept   = pl_valid & pl_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_pid  = 1'b0;
    take_hold = 1'b0;
    send_lo   = 1'b0;
    send_hi   = 1'b0;
    finish    = 1'b0;
    underrun  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        load_pid = 1'b1;
        state_d  = S_PID;
      end
      S_PID: if (tx_ready) begin
        if (!hd_q) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end else if (zlp_q) begin
          send_lo = 1'b1;
          state_d = S_CRC_LO;
        end else if (hold_full) begin
          take_hold = 1'b1;
          state_d   = S_DATA;
        end else begin
          underrun = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_DATA: if (tx_ready) begin
        if (cur_last) begin
          send_lo = 1'b1;
          state_d = S_CRC_LO;
        end else if (hold_full) begin
          take_hold = 1'b1;
        end else begin
          underrun = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_CRC_LO: if (tx_ready) begin
        send_hi = 1'b1;
        state_d = S_CRC_HI;
      end
      S_CRC_HI: if (tx_ready) begin
        finish  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      crc_q      <= 16'hFFFF;
      hold_data  <= 8'h00;
      hold_full  <= 1'b0;
      hold_last  <= 1'b0;
      fetch_done <= 1'b0;
      fetch_cnt  <= '0;
      hd_q       <= 1'b0;
      zlp_q      <= 1'b0;
      cur_last   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (load_pid) begin
        tx_data    <= {~pid, pid};
        tx_valid   <= 1'b1;
        busy       <= 1'b1;
        crc_q      <= 16'hFFFF;
        hd_q       <= has_data;
        zlp_q      <= zlp;
        hold_full  <= 1'b0;
        fetch_done <= 1'b0;
        fetch_cnt  <= '0;
        cur_last   <= 1'b0;
        ovf_q      <= 1'b0;
      end
      // The MAX_LEN-th fetched byte is forced to be last; without pl_last it flags overflow.
      if (accept) begin
        hold_data <= pl_data;
        hold_full <= 1'b1;
        fetch_cnt <= fetch_cnt + CW'(1);
        hold_last <= pl_last | (fetch_cnt == CW'(MAX_LEN - 1));
        if (pl_last || fetch_cnt == CW'(MAX_LEN - 1)) fetch_done <= 1'b1;
        if (!pl_last && fetch_cnt == CW'(MAX_LEN - 1)) ovf_q <= 1'b1;
      end
      if (take_hold) begin
        tx_data   <= hold_data;
        cur_last  <= hold_last;
        hold_full <= 1'b0;
        crc_q     <= crc16_byte(crc_q, hold_data);
      end
      if (send_lo) tx_data <= ~crc_q[7:0];
      if (send_hi) tx_data <= ~crc_q[15:8];
      if (finish || underrun) begin
        tx_valid <= 1'b0;
        busy     <= 1'b0;
        done     <= 1'b1;
        error    <= underrun | ovf_q;
      end
    end
  end

endmodule

// File: tb/tb_usb_sie_tx.sv
// Scoreboard bench for usb_sie_tx: a packet-level reference model queues the
// expected transceiver bytes and end status; a monitor checks them as consumed.
module tb_usb_sie_tx;
  localparam int MAX_LEN = 16;

  logic       clk, reset, start, has_data, zlp, pl_valid, pl_last, pl_ready;
  logic       tx_valid, tx_ready, busy, done, error;
  logic [3:0] pid;
  logic [7:0] pl_data, tx_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_bytes[$];
  logic       exp_err[$];
  logic [8:0] stim_q[$];
  logic [8:0] src_q[$];
  int src_pops = 0;
  int accepted = 0;
  int done_count = 0;
  int tx_count = 0;
  int done_base = 0;
  bit pl_ready_seen = 0;

  usb_sie_tx #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset(reset), .start(start), .pid(pid), .has_data(has_data), .zlp(zlp),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last), .pl_ready(pl_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Packet model: payload runs to the first pl_last, capped at MAX_LEN (overflow);
  // a stream that runs dry before either ends the packet early with error.
  function automatic int modelPacket(input logic [3:0] p, input logic hd, input logic z);
    logic [15:0] crc;
    logic        fb;
    int          n;
    bit          last_found;
    exp_bytes.push_back({~p, p});
    if (!hd) begin
      exp_err.push_back(1'b0);
      return 0;
    end
    if (z) begin
      exp_bytes.push_back(8'h00);
      exp_bytes.push_back(8'h00);
      exp_err.push_back(1'b0);
      return 0;
    end
    crc = 16'hFFFF;
    n = 0;
    last_found = 0;
    while (n < stim_q.size() && n < MAX_LEN && !last_found) begin
      exp_bytes.push_back(stim_q[n][7:0]);
      for (int b = 0; b < 8; b++) begin
        fb  = crc[0] ^ stim_q[n][b];
        crc = {1'b0, crc[15:1]};
        if (fb) crc = crc ^ 16'hA001;
      end
      last_found = stim_q[n][8];
      n++;
    end
    if (last_found || n == MAX_LEN) begin
      exp_bytes.push_back(~crc[7:0]);
      exp_bytes.push_back(~crc[15:8]);
      exp_err.push_back(!last_found);
    end else begin
      exp_err.push_back(1'b1);
    end
    return n;
  endfunction

  // Payload source: always offers its head byte; pops after each accepted handshake.
  initial begin
    pl_valid = 0; pl_last = 0; pl_data = 0;
    forever begin
      @(posedge clk); #1;
      while (src_pops > 0 && src_q.size() > 0) begin
        void'(src_q.pop_front());
        src_pops--;
      end
      src_pops = 0;
      if (src_q.size() > 0) begin
        pl_valid = 1; pl_last = src_q[0][8]; pl_data = src_q[0][7:0];
      end else begin
        pl_valid = 0; pl_last = 0; pl_data = 0;
      end
    end
  end

  // Transceiver model: spaced single-cycle tx_ready pulses, plus stray pulses while idle.
  initial begin
    int  cnt;
    bit  prev_valid;
    cnt = 0;
    prev_valid = 0;
    tx_ready = 0;
    forever begin
      @(posedge clk); #1;
      tx_ready = 0;
      if (tx_valid && !prev_valid) cnt = $urandom_range(1, 5);
      else if (tx_valid) begin
        if (cnt > 0) cnt--;
        else begin
          tx_ready = 1;
          cnt = $urandom_range(2, 6);
        end
      end else if ($urandom_range(0, 7) == 0) tx_ready = 1;
      prev_valid = tx_valid;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (tx_valid && tx_ready) begin
        tx_count++;
        if (exp_bytes.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL tx_byte_extra: got 0x%0h, expected no byte", tx_data);
        end else checkOutput("tx_byte", tx_data, exp_bytes.pop_front());
      end
      if (done) begin
        done_count++;
        if (exp_err.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL done_extra: got done=1, expected done=0");
        end else checkOutput("error_flag", error, exp_err.pop_front());
        checkOutput("busy_at_done", busy, 0);
        checkOutput("valid_at_done", tx_valid, 0);
      end else checkOutput("error_without_done", error, 0);
      if (pl_valid && pl_ready) begin
        accepted++;
        src_pops++;
      end
      if (pl_ready) pl_ready_seen = 1;
    end
  end

  task automatic startPacket(input logic [3:0] p, input logic hd, input logic z, output int exp_acc);
    src_q.delete();
    foreach (stim_q[i]) src_q.push_back(stim_q[i]);
    src_pops = 0;
    accepted = 0;
    pl_ready_seen = 0;
    done_base = done_count;
    exp_acc = modelPacket(p, hd, z);
    pid = p; has_data = hd; zlp = z; start = 1;
    @(posedge clk); #2;
    start = 0;
    pid = 4'($urandom); has_data = 1'($urandom); zlp = 1'($urandom);
    checkOutput("start_valid", tx_valid, 1);
    checkOutput("start_busy", busy, 1);
    checkOutput("pid_byte", tx_data, {~p, p});
  endtask

  task automatic finishPacket(input int exp_acc, input bit no_ready);
    int t;
    t = 0;
    while (done_count == done_base && t < 3000) begin
      @(posedge clk); #2;
      t++;
    end
    if (done_count == done_base) begin
      checks++; errors++;
      $display("[TB] FAIL done_timeout: got no done, expected done within 3000 cycles");
    end
    checkOutput("accepted_count", accepted, exp_acc);
    checkOutput("leftover_bytes", exp_bytes.size(), 0);
    if (no_ready) checkOutput("pl_ready_seen", pl_ready_seen, 0);
    exp_bytes.delete(); exp_err.delete(); src_q.delete(); src_pops = 0;
    @(posedge clk); #2;
  endtask

  task automatic applyStimulus(input logic [3:0] p, input logic hd, input logic z, input bit extra_start);
    int exp_acc;
    startPacket(p, hd, z, exp_acc);
    if (extra_start) begin
      repeat (2) @(posedge clk);
      #2; start = 1; pid = 4'h2; has_data = 0;
      @(posedge clk); #2; start = 0;
    end
    finishPacket(exp_acc, !hd || z);
  endtask

  initial begin
    int exp_acc, t, len, base_done;
    logic hd, z;
    reset = 0; start = 0; pid = 0; has_data = 0; zlp = 0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_tx_data", tx_data, 0);
    checkOutput("rst_tx_valid", tx_valid, 0);
    checkOutput("rst_pl_ready", pl_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_error", error, 0);
    reset = 1;
    @(posedge clk); #2;

    stim_q.delete();
    applyStimulus(4'h2, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'h3, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) stim_q.push_back({(i == 8), 8'(8'h31 + i)});
    applyStimulus(4'hB, 1'b1, 1'b0, 1'b1);
    stim_q.delete();
    stim_q.push_back({1'b0, 8'h01});
    applyStimulus(4'h3, 1'b1, 1'b0, 1'b0);
    stim_q.delete();
    for (int i = 0; i < MAX_LEN + 2; i++) stim_q.push_back({(i == MAX_LEN + 1), 8'(i)});
    applyStimulus(4'h3, 1'b1, 1'b0, 1'b0);
    stim_q.delete();
    for (int i = 0; i < MAX_LEN; i++) stim_q.push_back({(i == MAX_LEN - 1), 8'($urandom)});
    applyStimulus(4'hB, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of the payload, then a fresh packet.
    stim_q.delete();
    for (int i = 0; i < MAX_LEN; i++) stim_q.push_back({(i == MAX_LEN - 1), 8'(i + 8'h40)});
    t = tx_count;
    startPacket(4'h3, 1'b1, 1'b0, exp_acc);
    len = 0;
    while (tx_count < t + 3 && len < 500) begin
      @(posedge clk); #2;
      len++;
    end
    if (tx_count < t + 3) begin
      checks++; errors++;
      $display("[TB] FAIL data_timeout: got %0d bytes, expected 3 consumed", tx_count - t);
    end
    base_done = done_count;
    reset = 0;
    #1;
    checkOutput("mid_rst_tx_valid", tx_valid, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_pl_ready", pl_ready, 0);
    checkOutput("mid_rst_tx_data", tx_data, 0);
    exp_bytes.delete(); exp_err.delete(); src_q.delete(); src_pops = 0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("mid_rst_no_done", done_count, base_done);
    reset = 1;
    @(posedge clk); #2;
    stim_q.delete();
    applyStimulus(4'h2, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      hd = 1'($urandom);
      z = hd && ($urandom_range(0, 4) == 0);
      len = $urandom_range(0, MAX_LEN + 4);
      stim_q.delete();
      for (int i = 0; i < len; i++)
        stim_q.push_back({(i == len - 1) && ($urandom_range(0, 7) != 0), 8'($urandom)});
      applyStimulus(4'($urandom), hd, z, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
